// File: rtl/spdif_bmc_nibble_encoder.sv
// S/PDIF line-coding stage: serialises 4-bit transition nibbles MSB first on clk128.
// Each 1 bit toggles the line and each 0 bit holds it, so upstream builds BMC cells and preambles.
module spdif_bmc_nibble_encoder (
  input  logic       clk128,
  input  logic       reset,
  input  logic       i_valid,
  output logic       i_ready,
  input  logic [3:0] i_data,
  output logic       is_underrun,
  output logic       q
);

  localparam int unsigned NIBBLE_BITS = 4;
  localparam int unsigned CNT_W       = $clog2(NIBBLE_BITS);
  localparam logic [CNT_W-1:0] LAST_SLOT_CNT = CNT_W'(NIBBLE_BITS - 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NIBBLE_BITS-1:0] sh_q, sh_d;
  logic [NIBBLE_BITS-1:0] buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   q_q, q_d;
  logic                   underrun_q, underrun_d;

  // Slot timing, shifting, buffer handshake and line toggling.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    sh_d       = {sh_q[NIBBLE_BITS-2:0], 1'b0};
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = underrun_q;
    q_d        = q_q ^ sh_q[NIBBLE_BITS-1];

    if (cnt_q == LAST_SLOT_CNT) begin
      if (buf_full_q) begin
        sh_d       = buf_q;
        buf_full_d = 1'b0;
        underrun_d = 1'b0;
      end else begin
        sh_d       = '0;
        underrun_d = 1'b1;
      end
    end

    // Cannot collide with the boundary load: a full buffer deasserts i_ready.
    if (i_valid && !buf_full_q) begin
      buf_d      = i_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      sh_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      q_q        <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      q_q        <= q_d;
      underrun_q <= underrun_d;
    end
  end

  assign i_ready     = ~buf_full_q;
  assign is_underrun = underrun_q;
  assign q           = q_q;

endmodule

// File: tb/tb_spdif_bmc_nibble_encoder.sv
// Bench for spdif_bmc_nibble_encoder: directed preamble/subframe decode plus random traffic
// against a half-cell stream model.
module tb_spdif_bmc_nibble_encoder;

  logic       clk128 = 1'b0;
  logic       reset;
  logic       i_valid;
  logic       i_ready;
  logic [3:0] i_data;
  logic       is_underrun;
  logic       q;

  spdif_bmc_nibble_encoder dut (
    .clk128      (clk128),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .is_underrun (is_underrun),
    .q           (q)
  );

  always #5 clk128 = ~clk128;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a queue of pending half-cell transitions; every edge consumes one,
  // every fourth edge appends the buffered nibble (or four holds on underrun).
  bit          stream[$];
  bit          m_q, m_full, m_under, last_xfer;
  bit    [3:0] m_buf;
  int unsigned m_edge;

  task automatic model_reset();
    stream.delete();
    repeat (4) stream.push_back(1'b0);
    m_q = 0; m_full = 0; m_under = 0; m_buf = 4'h0; m_edge = 0; last_xfer = 0;
  endtask

  task automatic model_edge(input bit v, input bit [3:0] d);
    bit rdy;
    rdy = !m_full;
    m_q = m_q ^ stream.pop_front();
    if (m_edge % 4 == 3) begin
      if (m_full) begin
        for (int k = 3; k >= 0; k--) stream.push_back(m_buf[k]);
        m_full  = 0;
        m_under = 0;
      end else begin
        repeat (4) stream.push_back(1'b0);
        m_under = 1;
      end
    end
    last_xfer = v && rdy;
    if (last_xfer) begin
      m_buf  = d;
      m_full = 1;
    end
    m_edge++;
  endtask

  task automatic step(input bit v, input logic [3:0] d);
    i_valid = v;
    i_data  = v ? d : 4'($urandom);
    check("i_ready", 32'(i_ready), 32'(!m_full));
    @(posedge clk128);
    model_edge(v, d);
    #1;
    check("q", 32'(q), 32'(m_q));
    check("is_underrun", 32'(is_underrun), 32'(m_under));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_q", 32'(q), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_underrun", 32'(is_underrun), 32'd0);
    reset = 1'b0;
    #1;
  endtask

  logic [3:0] seq [16];
  bit         tr[$];
  bit         qs[$];
  logic [7:0]  pre_v, q_v;
  logic [27:0] data_v, start_v;
  int          idx;
  logic        prev_q;

  initial begin
    seq = '{4'h9, 4'hC, 4'hE, 4'hA, 4'hE, 4'hB, 4'hE, 4'hB,
            4'hA, 4'hB, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = 4'h0;
    do_reset();

    // Idle after reset: line holds 0, underrun from the first boundary on.
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0);
    check("idle_underrun", 32'(is_underrun), 32'd1);

    // Burst of preamble B, a subframe of data cells, then four data-0 cells.
    do_reset();
    idx = 0;
    for (int i = 0; i < 68; i++) begin
      prev_q = q;
      step(idx < 16, seq[(idx < 16) ? idx : 0]);
      if (last_xfer) idx++;
      if (i >= 4) begin
        tr.push_back(q ^ prev_q);
        qs.push_back(q);
      end
    end
    check("burst_count", 32'(idx), 32'd16);

    pre_v = '0;
    q_v   = '0;
    for (int j = 0; j < 8; j++) begin
      pre_v = {pre_v[6:0], tr[j]};
      q_v   = {q_v[6:0], qs[j]};
    end
    check("preamble_B_cells", 32'(pre_v), 32'h9C);
    check("preamble_B_q", 32'(q_v), 32'hE8);

    data_v  = '0;
    start_v = '0;
    for (int k = 0; k < 28; k++) begin
      start_v = {start_v[26:0], tr[8 + 2*k]};
      data_v  = {data_v[26:0], tr[9 + 2*k]};
    end
    check("cell_boundaries", 32'(start_v), 32'h0FFF_FFFF);
    check("decoded_data", 32'(data_v), 32'h0899_1000);

    // Starve, then resume with one nibble.
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0);
    check("starved_underrun", 32'(is_underrun), 32'd1);
    step(1'b1, 4'hB);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0);

    // Reset with a nibble sitting in the buffer mid-slot; it must never appear.
    for (int i = 0; i < 2; i++) step(1'b0, 4'h0);
    step(1'b1, 4'hF);
    step(1'b0, 4'h0);
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0);
    check("post_reset_q", 32'(q), 32'd0);

    // Random traffic with occasional mid-operation reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
